// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and types shared across the CPU slice.
//   RSTACK_DEPTH : default number of return-stack entries
//   PC_W         : program-counter / return-address width
//   ret_addr_t   : return-address type
//   ptr_w()      : pointer width for a power-of-two entry count
package cpu_pkg;

    localparam int unsigned RSTACK_DEPTH = 8;
    localparam int unsigned PC_W         = 12;

    typedef logic [PC_W-1:0] ret_addr_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/return_stack_if.sv
// return_stack_if -- controller <-> return-stack signal bundle.
//   master : controller side (drives push/pop/push_addr/err_clr)
//   slave  : stack side (drives top_addr, empty, full, count, overflow, underflow)
interface return_stack_if
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = RSTACK_DEPTH,
    parameter int unsigned ADDR_W = PC_W
);

    logic                      push;
    logic                      pop;
    logic [ADDR_W-1:0]         push_addr;
    logic                      err_clr;
    logic [ADDR_W-1:0]         top_addr;
    logic                      empty;
    logic                      full;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output push, pop, push_addr, err_clr,
        input  top_addr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, err_clr,
        output top_addr, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/rstack_mem.sv
// rstack_mem -- return-stack storage: synchronous write, asynchronous read,
// contents are not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : combinational read data
module rstack_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned SP_W   = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [SP_W-1:0]   waddr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [SP_W-1:0]   raddr_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// return_stack -- hardware return-address stack for JSB/RET.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (pointer, count, flags)
//   bus   : return_stack_if.slave
//           push/pop/push_addr/err_clr in; top_addr/empty/full/count/
//           overflow/underflow out
// Build option: define RSTACK_WRAP_EN to let a push while full overwrite the
// oldest entry instead of being dropped.
module return_stack
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = RSTACK_DEPTH,
    parameter int unsigned ADDR_W = PC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    return_stack_if.slave        bus
);

    localparam int unsigned SP_W  = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              we;
    logic [SP_W-1:0]   waddr;
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] rdata;
    logic              is_empty;
    logic              is_full;

    assign sp_m1    = sp_q - SP_W'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
        // Clear first so a same-cycle error event below overrides it.
        ovf_d   = bus.err_clr ? 1'b0 : ovf_q;
        unf_d   = bus.err_clr ? 1'b0 : unf_q;

        if (bus.push && bus.pop) begin
            if (is_empty) begin
                we      = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                count_d = CNT_W'(1);
            end else begin
                // Replace the top in place; depth unchanged, no flag even when full.
                we    = 1'b1;
                waddr = sp_m1;
            end
        end else if (bus.push) begin
            if (!is_full) begin
                we      = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                count_d = count_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef RSTACK_WRAP_EN
                // Circular overwrite of the oldest entry; count saturates.
                we   = 1'b1;
                sp_d = sp_q + SP_W'(1);
`endif
            end
        end else if (bus.pop) begin
            if (!is_empty) begin
                sp_d    = sp_m1;
                count_d = count_q - CNT_W'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage has no reset, so writes are gated to ignore pushes during reset.
    rstack_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .SP_W   (SP_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (we && rst_n),
        .waddr_i (waddr),
        .wdata_i (bus.push_addr),
        .raddr_i (sp_m1),
        .rdata_o (rdata)
    );

    assign bus.top_addr  = is_empty ? '0 : rdata;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack -- directed self-checking bench for return_stack.
module tb_return_stack;
    import cpu_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 12;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    return_stack_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, sample 1 time unit later.
    task automatic cyc(input logic p, input logic q, input ret_addr_t a, input logic c);
        bus.push      = p;
        bus.pop       = q;
        bus.push_addr = a;
        bus.err_clr   = c;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int unsigned cnt, input ret_addr_t top);
        chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
        chk({tag, "_top"}, 32'(bus.top_addr), 32'(top));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({tag, "_full"}, 32'(bus.full), 32'(cnt == DEPTH));
    endtask

    initial begin
        int unsigned base;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_addr = '0;
        bus.err_clr   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_state("rst", 0, 12'h000);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_unf", 32'(bus.underflow), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic push/pop
        cyc(1, 0, 12'h010, 0);
        chk_state("push1", 1, 12'h010);
        cyc(1, 0, 12'h020, 0);
        cyc(1, 0, 12'h030, 0);
        chk_state("push3", 3, 12'h030);
        cyc(0, 1, 12'h000, 0);
        chk_state("pop1", 2, 12'h020);
        cyc(0, 1, 12'h000, 0);
        chk_state("pop2", 1, 12'h010);
        cyc(0, 1, 12'h000, 0);
        chk_state("pop3", 0, 12'h000);

        // Underflow and err_clr priority
        cyc(0, 1, 12'h000, 0);
        chk_state("unf_pop", 0, 12'h000);
        chk("unf_set", 32'(bus.underflow), 32'd1);
        cyc(0, 0, 12'h000, 1);
        chk("unf_clr", 32'(bus.underflow), 32'd0);
        cyc(0, 1, 12'h000, 1);
        chk("unf_setwins", 32'(bus.underflow), 32'd1);
        cyc(0, 0, 12'h000, 1);
        chk("unf_clr2", 32'(bus.underflow), 32'd0);

        // Push+pop on empty acts as push
        cyc(1, 1, 12'h077, 0);
        chk_state("pp_empty", 1, 12'h077);
        chk("pp_empty_unf", 32'(bus.underflow), 32'd0);
        cyc(0, 1, 12'h000, 0);
        chk_state("pp_empty_pop", 0, 12'h000);

        // Push+pop replaces top
        cyc(1, 0, 12'h0A0, 0);
        cyc(1, 0, 12'h0B0, 0);
        cyc(1, 1, 12'h0C0, 0);
        chk_state("pp_repl", 2, 12'h0C0);
        cyc(0, 1, 12'h000, 0);
        chk_state("pp_repl_pop", 1, 12'h0A0);
        cyc(0, 1, 12'h000, 0);
        chk_state("pp_drain", 0, 12'h000);

        // Fill and overflow
        for (int i = 0; i < 8; i++) cyc(1, 0, ret_addr_t'(12'h100 + i), 0);
        chk_state("fill8", 8, 12'h107);
        chk("fill8_ovf", 32'(bus.overflow), 32'd0);
        cyc(1, 0, 12'h108, 0);
`ifdef RSTACK_WRAP_EN
        chk_state("push9", 8, 12'h108);
        base = 32'h108;
`else
        chk_state("push9", 8, 12'h107);
        base = 32'h107;
`endif
        chk("push9_ovf", 32'(bus.overflow), 32'd1);
        cyc(0, 0, 12'h000, 1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Push+pop while full: no flag
        cyc(1, 1, 12'h1FF, 0);
        chk_state("pp_full", 8, 12'h1FF);
        chk("pp_full_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 12'h000, 0);
            chk_state("drain", 8 - i, ret_addr_t'(base - i));
        end
        cyc(0, 1, 12'h000, 0);
        chk_state("drain_last", 0, 12'h000);
        chk("drain_unf", 32'(bus.underflow), 32'd0);

        // Asynchronous reset mid-cycle
        cyc(1, 0, 12'h055, 0);
        chk_state("pre_arst", 1, 12'h055);
        bus.push      = 1'b1;
        bus.push_addr = 12'h055;
        #2 rst_n = 1'b0;
        #1;
        chk_state("arst_imm", 0, 12'h000);
        @(posedge clk);
        #1;
        chk_state("arst_hold", 0, 12'h000);
        bus.push = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk_state("arst_rel", 0, 12'h000);
        cyc(1, 0, 12'h066, 0);
        chk_state("arst_push", 1, 12'h066);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
